adc_code_averager: RTL and testbench

ADC_CODE_AVERAGER -- requirements
Module: adc_code_averager

---
 rtl/adc_pkg.sv | 11 +
 rtl/adc_code_sync.sv | 29 ++
 rtl/adc_code_averager.sv | 131 +++++++++++++
 tb/tb_adc_code_averager.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC code averager: code width and FSM states.
package adc_pkg;

  localparam int ADC_BITS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/adc_code_sync.sv
// Two-flop synchronizer bringing the free-running ADC code into the clk domain.
module adc_code_sync
  import adc_pkg::*;
#(
  parameter int W = ADC_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  // Shift the asynchronous code through two flops; output is d delayed 2 clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/adc_code_averager.sv
// Averages 2^LOG2_AVG strobed ADC samples and hands results out over a
// valid/ready handshake, flagging dropped results with a sticky overrun.
module adc_code_averager
  import adc_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int LOG2_AVG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [ADC_BITS-1:0] code_in,
  input  logic                clr_ovr,
  output logic [ADC_BITS-1:0] avg_out,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic                overrun
);

  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ACC_W  = ADC_BITS + LOG2_AVG;
  localparam int SCNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << LOG2_AVG) - 1);
  // Half an LSB of the result; zero when no averaging is done.
  localparam logic [ACC_W:0]    RND       = (ACC_W + 1)'((1 << LOG2_AVG) >> 1);

  // Round-half-up divide of the window sum; the full-scale sum maps to 255.
  function automatic logic [ADC_BITS-1:0] round_avg(input logic [ACC_W-1:0] sum);
    logic [ACC_W:0] t;
    t = {1'b0, sum} + RND;
    return ADC_BITS'(t >> LOG2_AVG);
  endfunction

  state_t               state;
  state_t               state_nxt;
  logic                 run;
  logic [ADC_BITS-1:0]  sync_code;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  logic [SCNT_W-1:0]    scnt;
  logic                 strobe;
  logic                 complete;
  logic [ACC_W-1:0]     sum_nxt;
  logic [ADC_BITS-1:0]  result;
  logic                 load;
  logic                 drop;
  logic                 xfer;

  adc_code_sync #(
    .W(ADC_BITS)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (code_in),
    .q    (sync_code)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: follow en; run marks cycles where the strobe counter advances.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = ACCUM;
      ACCUM: begin
        if (en) run       = 1'b1;
        else    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign strobe   = run && (cnt == CNT_LAST);
  assign complete = strobe && (scnt == SCNT_LAST);
  assign sum_nxt  = acc + ACC_W'(sync_code);
  assign result   = round_avg(sum_nxt);
  assign xfer     = avg_valid && avg_ready;
  assign load     = complete && (!avg_valid || avg_ready);
  assign drop     = complete && avg_valid && !avg_ready;

  // Strobe counter and window accumulator; cleared whenever not running so
  // a dropped en discards the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      scnt <= '0;
    end else if (!run) begin
      cnt  <= '0;
      acc  <= '0;
      scnt <= '0;
    end else begin
      cnt <= strobe ? '0 : cnt + CNT_W'(1);
      if (complete) begin
        acc  <= '0;
        scnt <= '0;
      end else if (strobe) begin
        acc  <= sum_nxt;
        scnt <= scnt + SCNT_W'(1);
      end
    end
  end

  // Output register: load a finished result unless the old one is stuck.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else if (load) begin
      avg_out   <= result;
      avg_valid <= 1'b1;
    end else if (xfer) begin
      avg_valid <= 1'b0;
    end
  end

  // Sticky overrun: a drop sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_adc_code_averager.sv
// Directed bench for adc_code_averager (DIV=4, LOG2_AVG=2).
module tb_adc_code_averager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] code_in;
  logic       clr_ovr;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       avg_ready;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  adc_code_averager #(
    .DIV     (4),
    .LOG2_AVG(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .code_in  (code_in),
    .clr_ovr  (clr_ovr),
    .avg_out  (avg_out),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    vecs[1] = '{8'd10, 8'd11, 8'd11, 8'd11, 8'd11};
    vecs[2] = '{8'd0,  8'd0,  8'd0,  8'd2,  8'd1};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[4] = '{8'd0,  8'd0,  8'd0,  8'd1,  8'd0};
    vecs[5] = '{8'd1,  8'd1,  8'd1,  8'd3,  8'd2};
    vecs[6] = '{8'd0,  8'd0,  8'd1,  8'd1,  8'd1};
    vecs[7] = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd102};

    rst_n = 1'b0; en = 1'b0; code_in = 8'h00; clr_ovr = 1'b0; avg_ready = 1'b0;
    #1;
    check("reset_avg_out", avg_out, 8'h00);
    check("reset_avg_valid", avg_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Table: one isolated window per vector, result held with ready low.
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; code_in = vecs[i].s0;
      tick();                                  // en seen high
      repeat (4) tick(); code_in = vecs[i].s1;
      repeat (4) tick(); code_in = vecs[i].s2;
      repeat (4) tick(); code_in = vecs[i].s3;
      repeat (3) tick();
      check($sformatf("vec%0d_valid_early", i), avg_valid, 1'b0);
      tick();
      check($sformatf("vec%0d_valid", i), avg_valid, 1'b1);
      check($sformatf("vec%0d_avg_out", i), avg_out, vecs[i].exp);
      en = 1'b0; avg_ready = 1'b1;
      tick();
      avg_ready = 1'b0;
      check($sformatf("vec%0d_xfer_valid", i), avg_valid, 1'b0);
    end

    // Constant code with ready high: one-cycle pulse every 16 clk.
    code_in = 8'h80; avg_ready = 1'b1; en = 1'b1;
    tick();
    for (int t = 1; t <= 40; t++) begin
      tick();
      check($sformatf("const_valid_t%0d", t), avg_valid, (t == 16 || t == 32));
      if (t == 16 || t == 32) check($sformatf("const_out_t%0d", t), avg_out, 8'h80);
    end
    en = 1'b0; avg_ready = 1'b0;
    tick();

    // Backpressure: first result held, second dropped (with coincident clear).
    code_in = 8'h40; en = 1'b1;
    tick();
    for (int t = 1; t <= 40; t++) begin
      if (t == 32) clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      if (t == 16) begin
        check("bp_first_valid", avg_valid, 1'b1);
        check("bp_first_out", avg_out, 8'h40);
        code_in = 8'h20;
      end
      if (t == 24) check("bp_hold_out", avg_out, 8'h40);
      if (t == 31) check("bp_ovr_before", overrun, 1'b0);
      if (t == 32) begin
        check("bp_ovr_set", overrun, 1'b1);
        check("bp_drop_out", avg_out, 8'h40);
        check("bp_drop_valid", avg_valid, 1'b1);
      end
    end
    avg_ready = 1'b1;
    tick();
    check("bp_xfer_valid", avg_valid, 1'b0);
    check("bp_ovr_sticky", overrun, 1'b1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("bp_ovr_clear", overrun, 1'b0);
    en = 1'b0; avg_ready = 1'b0;
    tick();

    // Transfer in the same cycle as the next completion.
    code_in = 8'h10; en = 1'b1;
    tick();
    for (int t = 1; t <= 33; t++) begin
      if (t == 32) avg_ready = 1'b1;
      tick();
      if (t == 16) begin
        check("sim_first_out", avg_out, 8'h10);
        code_in = 8'h30;
      end
      if (t == 31) begin
        check("sim_pre_valid", avg_valid, 1'b1);
        check("sim_pre_out", avg_out, 8'h10);
      end
      if (t == 32) begin
        check("sim_valid", avg_valid, 1'b1);
        check("sim_new_out", avg_out, 8'h30);
        check("sim_ovr", overrun, 1'b0);
      end
      if (t == 33) check("sim_after_valid", avg_valid, 1'b0);
    end
    en = 1'b0; avg_ready = 1'b0;
    tick();

    // en drop after two strobes: partial discarded, pending result kept.
    code_in = 8'h50; en = 1'b1;
    tick();
    repeat (16) tick();
    check("endrop_first_out", avg_out, 8'h50);
    code_in = 8'hF0;
    repeat (8) tick();
    en = 1'b0;
    repeat (3) tick();
    check("endrop_pending_valid", avg_valid, 1'b1);
    check("endrop_pending_out", avg_out, 8'h50);
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    check("endrop_xfer_valid", avg_valid, 1'b0);
    code_in = 8'h08; en = 1'b1;
    tick();
    repeat (15) tick();
    check("endrop_no_early", avg_valid, 1'b0);
    tick();
    check("endrop_fresh_valid", avg_valid, 1'b1);
    check("endrop_fresh_out", avg_out, 8'h08);
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0; en = 1'b0;
    tick();

    // Reset at sample 3 of a window with a result pending and overrun set.
    code_in = 8'h60; en = 1'b1;
    tick();
    for (int t = 1; t <= 44; t++) begin
      tick();
      if (t == 32) check("rst_pre_ovr", overrun, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_async_out", avg_out, 8'h00);
    check("rst_async_valid", avg_valid, 1'b0);
    check("rst_async_ovr", overrun, 1'b0);
    code_in = 8'h70;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();                                    // en seen high
    repeat (15) tick();
    check("rst_no_early", avg_valid, 1'b0);
    tick();
    check("rst_first_valid", avg_valid, 1'b1);
    check("rst_first_out", avg_out, 8'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
